wb_slave_decoder: RTL and testbench
===================================

Name: wb_slave_decoder

Overview:
- Wishbone address decoder and single-master router sitting directly downstream of the LIMB-to-Wishbone master in the northbridge.
- Accepts one master cycle, selects one of NSLAVE slaves from the top address bits, and forwards the cycle.
- Registers the slave's response back to the master.
- Guards against hung slaves with a watchdog timeout that returns an error pattern instead of stalling the LIMB bus.

Parameters:
- NSLAVE, 4, number of attached slaves (1..2**SEL_BITS).
- SEL_BITS, 2, width of slave-select field, taken from m_adr_i[35 -: SEL_BITS].
- TIMEOUT, 255, cycles in BUSY without ack before forced error completion (1..65535).
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout or unmapped access.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_adr_i  in  36  master address.
- m_dat_i  in  32  master write data.
- m_sel_i  in  4  master byte selects.
- m_we_i  in  1  master write enable.
- m_stb_i  in  1  master strobe.
- m_cyc_i  in  1  master cycle.
- m_dat_o  out  32  read data to master, registered.
- m_ack_o  out  1  ack to master, single-cycle pulse, registered.
- s_adr_o  out  36  address to all slaves, registered at cycle start.
- s_dat_o  out  32  write data to all slaves, registered.
- s_sel_o  out  4  byte selects to all slaves, registered.
- s_we_o  out  1  write enable to all slaves, registered.
- s_cyc_o  out  NSLAVE  per-slave cycle, one-hot or zero.
- s_stb_o  out  NSLAVE  per-slave strobe, equal to s_cyc_o.
- s_dat_i  in  32*NSLAVE  slave read data, slave k at [32*k +: 32].
- s_ack_i  in  NSLAVE  slave acks.
- err_o  out  1  sticky: a timeout or unmapped access has occurred.
- err_slave_o  out  SEL_BITS  select field of the most recent error.
- err_clr_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all outputs 0, timeout counter 0. Asserting reset mid-cycle drops s_cyc_o/s_stb_o immediately; the master sees no ack.
- IDLE:
  - On m_cyc_i & m_stb_i, latch adr/dat/sel/we into the s_* registers.
  - Compute idx=m_adr_i[35 -: SEL_BITS].
  - If idx < NSLAVE: set bit idx of s_cyc_o/s_stb_o; go BUSY; clear counter.
  - Else (unmapped): go RESP with error.
- BUSY:
  - Only s_ack_i[idx] is honoured; other slaves' acks are ignored.
  - On ack: capture s_dat_i[idx] into m_dat_o (write cycles also capture, don't-care); drop s_cyc_o/s_stb_o the next edge; go RESP.
  - Else if the counter reaches TIMEOUT-1: drop the slave strobe; m_dat_o=ERR_DATA; go RESP with error.
  - Else increment the counter.
  - An ack and the timeout on the same cycle: the ack wins, no error.
- RESP: m_ack_o=1 for exactly this cycle; go WAIT.
  - On error: err_o<=1 and err_slave_o<=idx in the same edge that enters RESP.
- WAIT: stay until m_stb_i=0, then go IDLE. This prevents a held strobe from starting a second cycle.
- Latency: mapped slave acking combinationally in the first BUSY cycle gives m_ack_o 3 clk after m_stb_i is sampled. Unmapped access gives m_ack_o 2 clk after.
- Master dropping m_cyc_i in BUSY:
  - Abort: drop slave strobes, go IDLE, no m_ack_o.
  - If the abort coincides with the slave ack, the data is discarded.
- err_clr_i: clears err_o in any state. Simultaneous set and clear: set wins.
- m_dat_o holds its value until the next capture.

Optional Feature:
- Macro: WB_SLAVE_DECODER_TIMEOUT_EN.
- Defined: watchdog as described above.
- Undefined:
  - No counter is instantiated; BUSY waits indefinitely for the slave ack.
  - err_o is asserted only for unmapped accesses.
  - The TIMEOUT parameter is ignored.

Decomposition:
- Shared package/include holds:
  - State one-hot localparams: IDLE=1<<0, BUSY=1<<1, RESP=1<<2, WAIT=1<<3.
  - The ERR_DATA default constant.
  - The 36/32-bit Wishbone width constants shared with the LIMB master.
- One sub-module, wb_watchdog: counter with clear/enable/expire, compiled only under the macro.

Test Plan:
- Write 0x12345678 to adr 36'h4_0000_0010 (idx 1), slave 1 acks after 2 cycles:
  - s_cyc_o=4'b0010, s_dat_o=0x12345678, s_we_o=1.
  - Single m_ack_o pulse; err_o=0.
- Read from idx 3, slave returns 0xCAFEF00D with immediate ack → m_dat_o=0xCAFEF00D; m_ack_o exactly 3 cycles after strobe.
- NSLAVE=3, access idx 3:
  - No s_cyc_o bit is set.
  - m_dat_o=0xDEADBEEF with ack after 2 cycles.
  - err_o=1, err_slave_o=3.
- Macro defined, TIMEOUT=8, slave 0 never acks:
  - s_cyc_o[0] is high for 8 cycles then drops.
  - m_dat_o=0xDEADBEEF; err_o=1.
  - Then err_clr_i pulse → err_o=0.
- Master holds m_stb_i for 5 cycles after ack → only one slave cycle and one m_ack_o; a spurious s_ack_i[2] during a slave-0 access is ignored.
- Assert reset_n=0 mid-BUSY → s_cyc_o=0 asynchronously, no m_ack_o, state IDLE after release.

Source files
------------

// File: rtl/wb_slave_decoder_pkg.sv
// Shared constants and types for the Wishbone slave decoder and its watchdog.
// The Wishbone bus widths are the same ones the LIMB-to-Wishbone master uses.
package wb_slave_decoder_pkg;

   localparam int unsigned WbAdrWidth = 36;
   localparam int unsigned WbDatWidth = 32;
   localparam int unsigned WbSelWidth = WbDatWidth / 8;

   // Read data returned for a timed-out or unmapped access.
   localparam logic [WbDatWidth-1:0] WbErrData = 32'hDEADBEEF;

   // One-hot state codes.
   localparam logic [3:0] IdleOh = 4'b0001;
   localparam logic [3:0] BusyOh = 4'b0010;
   localparam logic [3:0] RespOh = 4'b0100;
   localparam logic [3:0] WaitOh = 4'b1000;

   typedef enum logic [3:0] {
      StIdle = IdleOh,
      StBusy = BusyOh,
      StResp = RespOh,
      StWait = WaitOh
   } state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Hung-slave watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT-th cycle. Only compiled when WB_SLAVE_DECODER_TIMEOUT_EN is defined.
`ifdef WB_SLAVE_DECODER_TIMEOUT_EN
module wb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [15:0] count_q;

   // Expiry is combinational so the caller can act on the last waiting cycle.
   assign expire_o = en_i && (count_q == 16'(TIMEOUT - 1));

   // Cycle counter, held at zero whenever the caller is not waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i && !expire_o) begin
         count_q <= count_q + 16'd1;
      end
   end

endmodule
`endif

// File: rtl/wb_slave_decoder.sv
// Wishbone address decoder / single-master router. Selects one of NSLAVE slaves
// from the top SEL_BITS address bits, forwards the cycle with registered
// outputs and returns a registered single-cycle ack to the master.
// Build option: WB_SLAVE_DECODER_TIMEOUT_EN adds a watchdog that completes a
// hung slave access with ERR_DATA and flags an error.
module wb_slave_decoder
   import wb_slave_decoder_pkg::*;
#(
   parameter int unsigned           NSLAVE   = 4,
   parameter int unsigned           SEL_BITS = 2,
   parameter int unsigned           TIMEOUT  = 255,
   parameter logic [WbDatWidth-1:0] ERR_DATA = WbErrData
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [WbAdrWidth-1:0]        m_adr_i,
   input  logic [WbDatWidth-1:0]        m_dat_i,
   input  logic [WbSelWidth-1:0]        m_sel_i,
   input  logic                         m_we_i,
   input  logic                         m_stb_i,
   input  logic                         m_cyc_i,
   output logic [WbDatWidth-1:0]        m_dat_o,
   output logic                         m_ack_o,
   output logic [WbAdrWidth-1:0]        s_adr_o,
   output logic [WbDatWidth-1:0]        s_dat_o,
   output logic [WbSelWidth-1:0]        s_sel_o,
   output logic                         s_we_o,
   output logic [NSLAVE-1:0]            s_cyc_o,
   output logic [NSLAVE-1:0]            s_stb_o,
   input  logic [WbDatWidth*NSLAVE-1:0] s_dat_i,
   input  logic [NSLAVE-1:0]            s_ack_i,
   output logic                         err_o,
   output logic [SEL_BITS-1:0]          err_slave_o,
   input  logic                         err_clr_i
);

   // Elaboration-time parameter sanity checks.
   if (NSLAVE == 0 || NSLAVE > (1 << SEL_BITS)) begin : g_bad_nslave
      $error("wb_slave_decoder: NSLAVE must be 1..2**SEL_BITS");
   end
   if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_slave_decoder: TIMEOUT must be 1..65535");
   end

   state_e                  state_q, state_d;
   logic [SEL_BITS-1:0]     idx_q, idx_d;
   logic [WbAdrWidth-1:0]   s_adr_q, s_adr_d;
   logic [WbDatWidth-1:0]   s_dat_q, s_dat_d;
   logic [WbSelWidth-1:0]   s_sel_q, s_sel_d;
   logic                    s_we_q, s_we_d;
   logic [NSLAVE-1:0]       s_cyc_q, s_cyc_d;
   logic [WbDatWidth-1:0]   m_dat_q, m_dat_d;
   logic                    m_ack_q;
   logic                    err_q, err_d;
   logic [SEL_BITS-1:0]     err_slave_q, err_slave_d;
   logic                    err_set;

   logic [SEL_BITS-1:0]     idx_in;
   logic                    mapped_in;
   logic                    sel_ack;
   logic [WbDatWidth-1:0]   sel_dat;
   logic                    wd_expire;

   assign idx_in    = m_adr_i[WbAdrWidth-1 -: SEL_BITS];
   assign mapped_in = 32'(idx_in) < NSLAVE;

`ifdef WB_SLAVE_DECODER_TIMEOUT_EN
   logic busy;
   assign busy = (state_q == StBusy);

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (!busy),
      .en_i     (busy),
      .expire_o (wd_expire)
   );
`else
   // Without the watchdog a hung slave stalls the master indefinitely.
   assign wd_expire = 1'b0;
`endif

   // Pick the ack and read data of the selected slave only; others are ignored.
   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int k = 0; k < int'(NSLAVE); k++) begin
         if (idx_q == SEL_BITS'(k)) begin
            sel_ack = s_ack_i[k];
            sel_dat = s_dat_i[WbDatWidth*k +: WbDatWidth];
         end
      end
   end

   // Next-state and registered-output logic for the cycle FSM and error flag.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      s_adr_d     = s_adr_q;
      s_dat_d     = s_dat_q;
      s_sel_d     = s_sel_q;
      s_we_d      = s_we_q;
      s_cyc_d     = s_cyc_q;
      m_dat_d     = m_dat_q;
      err_d       = err_q;
      err_slave_d = err_slave_q;
      err_set     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (m_cyc_i && m_stb_i) begin
               s_adr_d = m_adr_i;
               s_dat_d = m_dat_i;
               s_sel_d = m_sel_i;
               s_we_d  = m_we_i;
               idx_d   = idx_in;
               if (mapped_in) begin
                  s_cyc_d = NSLAVE'(1) << idx_in;
                  state_d = StBusy;
               end else begin
                  m_dat_d = ERR_DATA;
                  err_set = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StBusy: begin
            // Abort beats ack, ack beats timeout.
            if (!m_cyc_i) begin
               s_cyc_d = '0;
               state_d = StIdle;
            end else if (sel_ack) begin
               m_dat_d = sel_dat;
               s_cyc_d = '0;
               state_d = StResp;
            end else if (wd_expire) begin
               m_dat_d = ERR_DATA;
               s_cyc_d = '0;
               err_set = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StWait;
         end
         StWait: begin
            // A strobe still held from the finished cycle must not start another.
            if (!m_stb_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            s_cyc_d = '0;
            state_d = StIdle;
         end
      endcase

      // A new error wins over a simultaneous clear.
      if (err_set) begin
         err_d       = 1'b1;
         err_slave_d = idx_d;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   // State and output registers; reset drops slave strobes immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         s_adr_q     <= '0;
         s_dat_q     <= '0;
         s_sel_q     <= '0;
         s_we_q      <= 1'b0;
         s_cyc_q     <= '0;
         m_dat_q     <= '0;
         m_ack_q     <= 1'b0;
         err_q       <= 1'b0;
         err_slave_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         s_adr_q     <= s_adr_d;
         s_dat_q     <= s_dat_d;
         s_sel_q     <= s_sel_d;
         s_we_q      <= s_we_d;
         s_cyc_q     <= s_cyc_d;
         m_dat_q     <= m_dat_d;
         m_ack_q     <= (state_q == StResp);
         err_q       <= err_d;
         err_slave_q <= err_slave_d;
      end
   end

   assign m_dat_o     = m_dat_q;
   assign m_ack_o     = m_ack_q;
   assign s_adr_o     = s_adr_q;
   assign s_dat_o     = s_dat_q;
   assign s_sel_o     = s_sel_q;
   assign s_we_o      = s_we_q;
   assign s_cyc_o     = s_cyc_q;
   assign s_stb_o     = s_cyc_q;
   assign err_o       = err_q;
   assign err_slave_o = err_slave_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Testbench for wb_slave_decoder (NSLAVE=3 so select value 3 is unmapped).
// Expected outputs are tracked per cycle from transaction-level timing rules
// and compared on every falling edge; literal checks pin key results.
module tb_wb_slave_decoder;

   localparam int unsigned NS = 3;
   localparam int unsigned SB = 2;
   localparam int unsigned TO = 8;
`ifdef WB_SLAVE_DECODER_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n;
   logic [35:0]     m_adr_i;
   logic [31:0]     m_dat_i;
   logic [3:0]      m_sel_i;
   logic            m_we_i, m_stb_i, m_cyc_i;
   logic [31:0]     m_dat_o;
   logic            m_ack_o;
   logic [35:0]     s_adr_o;
   logic [31:0]     s_dat_o;
   logic [3:0]      s_sel_o;
   logic            s_we_o;
   logic [NS-1:0]   s_cyc_o, s_stb_o;
   logic [32*NS-1:0] s_dat_i;
   logic [NS-1:0]   s_ack_i;
   logic            err_o;
   logic [SB-1:0]   err_slave_o;
   logic            err_clr_i;

   wb_slave_decoder #(
      .NSLAVE   (NS),
      .SEL_BITS (SB),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m_adr_i     (m_adr_i),
      .m_dat_i     (m_dat_i),
      .m_sel_i     (m_sel_i),
      .m_we_i      (m_we_i),
      .m_stb_i     (m_stb_i),
      .m_cyc_i     (m_cyc_i),
      .m_dat_o     (m_dat_o),
      .m_ack_o     (m_ack_o),
      .s_adr_o     (s_adr_o),
      .s_dat_o     (s_dat_o),
      .s_sel_o     (s_sel_o),
      .s_we_o      (s_we_o),
      .s_cyc_o     (s_cyc_o),
      .s_stb_o     (s_stb_o),
      .s_dat_i     (s_dat_i),
      .s_ack_i     (s_ack_i),
      .err_o       (err_o),
      .err_slave_o (err_slave_o),
      .err_clr_i   (err_clr_i)
   );

   // Expected output values for the current cycle.
   logic [31:0]   e_m_dat;
   logic          e_ack;
   logic [35:0]   e_s_adr;
   logic [31:0]   e_s_dat;
   logic [3:0]    e_s_sel;
   logic          e_s_we;
   logic [NS-1:0] e_s_cyc;
   logic          e_err;
   logic [SB-1:0] e_err_slave;

   int n_cmp = 0;
   int n_bad = 0;

   // Monotonic activity counters, read as deltas by the directed tests.
   int ack_cnt = 0;
   int cyc_hi [NS] = '{default: 0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t: bound expired", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_expect();
      e_m_dat = '0; e_ack = 1'b0; e_s_adr = '0; e_s_dat = '0; e_s_sel = '0;
      e_s_we = 1'b0; e_s_cyc = '0; e_err = 1'b0; e_err_slave = '0;
   endtask

   // Every-cycle comparison against the expectation model.
   always @(negedge clk) begin
      chk("m_ack_o", 64'(m_ack_o), 64'(e_ack));
      chk("m_dat_o", 64'(m_dat_o), 64'(e_m_dat));
      chk("s_adr_o", 64'(s_adr_o), 64'(e_s_adr));
      chk("s_dat_o", 64'(s_dat_o), 64'(e_s_dat));
      chk("s_sel_o", 64'(s_sel_o), 64'(e_s_sel));
      chk("s_we_o", 64'(s_we_o), 64'(e_s_we));
      chk("s_cyc_o", 64'(s_cyc_o), 64'(e_s_cyc));
      chk("s_stb_o", 64'(s_stb_o), 64'(e_s_cyc));
      chk("err_o", 64'(err_o), 64'(e_err));
      chk("err_slave_o", 64'(err_slave_o), 64'(e_err_slave));
   end

   always @(negedge clk) begin
      if (m_ack_o === 1'b1) ack_cnt++;
      for (int k = 0; k < int'(NS); k++) begin
         if (s_cyc_o[k] === 1'b1) cyc_hi[k]++;
      end
   end

   // One master cycle. lat: busy cycle (0-based) in which the slave acks, -1 never.
   // spur: another slave index that acks spuriously while waiting, -1 none.
   // ack_delay: clock edges from strobe sampling to the visible m_ack_o.
   task automatic do_cycle(input logic [35:0] adr, input logic [31:0] wdat, input logic we,
                           input int lat, input logic [31:0] rdat, input int hold,
                           input int spur, input logic clr0, output int ack_delay);
      int  idx;
      int  b;
      int  t;
      bit  acked;
      idx = int'(adr[35:34]);
      m_adr_i = adr; m_dat_i = wdat; m_sel_i = 4'hF; m_we_i = we;
      m_cyc_i = 1'b1; m_stb_i = 1'b1; err_clr_i = clr0;
      t = 0;
      tick(); t++;
      err_clr_i = 1'b0;
      e_s_adr = adr; e_s_dat = wdat; e_s_sel = 4'hF; e_s_we = we;
      if (idx < int'(NS)) begin
         e_s_cyc = '0;
         e_s_cyc[idx] = 1'b1;
         acked = 1'b0;
         b = 0;
         while (1) begin
            s_ack_i = '0;
            if (spur >= 0 && b != lat) s_ack_i[spur] = 1'b1;
            if (b == lat) begin
               s_ack_i[idx] = 1'b1;
               s_dat_i[32*idx +: 32] = rdat;
            end
            tick(); t++;
            s_ack_i = '0;
            if (b == lat) begin
               acked = 1'b1;
               break;
            end
            if (TimeoutEn && b == int'(TO) - 1) break;
            if (b > 400) begin
               fail_now("busy_wait");
               break;
            end
            b++;
         end
         e_s_cyc = '0;
         e_m_dat = acked ? rdat : 32'hDEADBEEF;
         if (!acked) begin
            e_err = 1'b1;
            e_err_slave = adr[35:34];
         end
      end else begin
         e_m_dat = 32'hDEADBEEF;
         e_err = 1'b1;
         e_err_slave = adr[35:34];
      end
      tick(); t++;
      e_ack = 1'b1;
      ack_delay = t;
      tick();
      e_ack = 1'b0;
      for (int h = 0; h < hold; h++) tick();
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      tick();
   endtask

   task automatic clr_err();
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      e_err = 1'b0;
   endtask

   // Master gives up while the slave is still busy, optionally as it acks.
   task automatic do_abort(input logic [35:0] adr, input bit with_ack);
      int idx;
      idx = int'(adr[35:34]);
      m_adr_i = adr; m_dat_i = 32'h0; m_sel_i = 4'h3; m_we_i = 1'b0;
      m_cyc_i = 1'b1; m_stb_i = 1'b1;
      tick();
      e_s_adr = adr; e_s_dat = 32'h0; e_s_sel = 4'h3; e_s_we = 1'b0;
      e_s_cyc = '0;
      e_s_cyc[idx] = 1'b1;
      tick();
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      if (with_ack) begin
         s_ack_i[idx] = 1'b1;
         s_dat_i[32*idx +: 32] = 32'h5555AAAA;
      end
      tick();
      s_ack_i = '0;
      e_s_cyc = '0;
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL global_time_limit at %0t", $time);
      $fatal(1);
   end

   initial begin
      int d;
      int a0;
      int c0 [NS];
      logic [31:0] prev_dat;

      reset_n = 1'b0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = 1'b0;
      m_stb_i = 1'b0; m_cyc_i = 1'b0; s_dat_i = '0; s_ack_i = '0; err_clr_i = 1'b0;
      zero_expect();
      tick();
      tick();
      chk("reset_ack", 64'(m_ack_o), 64'h0);
      chk("reset_cyc", 64'(s_cyc_o), 64'h0);
      chk("reset_err", 64'(err_o), 64'h0);
      reset_n = 1'b1;
      tick();

      // Write to slave 1, ack after two wait cycles.
      a0 = ack_cnt; c0 = cyc_hi;
      do_cycle(36'h4_0000_0010, 32'h12345678, 1'b1, 2, 32'h0, 0, -1, 1'b0, d);
      chk("wr_cyc1_cycles", 64'(cyc_hi[1] - c0[1]), 64'd3);
      chk("wr_other_cycles", 64'(cyc_hi[0] - c0[0] + cyc_hi[2] - c0[2]), 64'd0);
      chk("wr_s_dat", 64'(s_dat_o), 64'h12345678);
      chk("wr_s_we", 64'(s_we_o), 64'h1);
      chk("wr_acks", 64'(ack_cnt - a0), 64'd1);
      chk("wr_err", 64'(err_o), 64'h0);

      // Read from slave 2 with an immediate ack.
      do_cycle(36'h8_0000_0040, 32'h0, 1'b0, 0, 32'hCAFEF00D, 0, -1, 1'b0, d);
      chk("rd_dat", 64'(m_dat_o), 64'hCAFEF00D);
      chk("rd_latency", 64'(d), 64'd3);

      // Unmapped select 3, with a clear arriving on the same edge as the error.
      a0 = ack_cnt; c0 = cyc_hi;
      do_cycle(36'hC_0000_0000, 32'h0, 1'b0, 0, 32'h0, 0, -1, 1'b1, d);
      chk("unm_no_cyc", 64'(cyc_hi[0] - c0[0] + cyc_hi[1] - c0[1] + cyc_hi[2] - c0[2]), 64'd0);
      chk("unm_dat", 64'(m_dat_o), 64'hDEADBEEF);
      chk("unm_latency", 64'(d), 64'd2);
      chk("unm_err", 64'(err_o), 64'h1);
      chk("unm_err_slave", 64'(err_slave_o), 64'h3);
      clr_err();
      chk("clr_err", 64'(err_o), 64'h0);

      // Held strobe after ack plus a spurious ack from slave 2 during a slave-0 access.
      a0 = ack_cnt; c0 = cyc_hi;
      do_cycle(36'h0_0000_0100, 32'hA5A5A5A5, 1'b1, 2, 32'h0, 5, 2, 1'b0, d);
      chk("hold_acks", 64'(ack_cnt - a0), 64'd1);
      chk("hold_cyc0", 64'(cyc_hi[0] - c0[0]), 64'd3);
      chk("hold_cyc2", 64'(cyc_hi[2] - c0[2]), 64'd0);

      // Ack on the last cycle before the watchdog would expire: ack wins.
      do_cycle(36'h4_0000_0020, 32'h0, 1'b0, int'(TO) - 1, 32'h0BADF00D, 0, -1, 1'b0, d);
      chk("late_ack_dat", 64'(m_dat_o), 64'h0BADF00D);
      chk("late_ack_err", 64'(err_o), 64'h0);

`ifdef WB_SLAVE_DECODER_TIMEOUT_EN
      // Slave 0 never acks.
      c0 = cyc_hi;
      do_cycle(36'h0_0000_0200, 32'h0, 1'b0, -1, 32'h0, 0, -1, 1'b0, d);
      chk("to_cyc0", 64'(cyc_hi[0] - c0[0]), 64'd8);
      chk("to_dat", 64'(m_dat_o), 64'hDEADBEEF);
      chk("to_err", 64'(err_o), 64'h1);
      chk("to_err_slave", 64'(err_slave_o), 64'h0);
      chk("to_latency", 64'(d), 64'd10);
      clr_err();
      chk("to_clr", 64'(err_o), 64'h0);
`endif

      // Aborts: plain, and coinciding with the slave ack (data discarded).
      a0 = ack_cnt;
      prev_dat = m_dat_o;
      do_abort(36'h4_0000_0300, 1'b0);
      do_abort(36'h8_0000_0304, 1'b1);
      chk("abort_acks", 64'(ack_cnt - a0), 64'd0);
      chk("abort_dat", 64'(m_dat_o), 64'(prev_dat));

      // Reset in the middle of a slave-2 access.
      a0 = ack_cnt;
      m_adr_i = 36'h8_0000_0080; m_dat_i = 32'h0; m_sel_i = 4'hF; m_we_i = 1'b0;
      m_cyc_i = 1'b1; m_stb_i = 1'b1;
      tick();
      e_s_adr = 36'h8_0000_0080; e_s_dat = 32'h0; e_s_sel = 4'hF; e_s_we = 1'b0;
      e_s_cyc = 3'b100;
      tick();
      #2;
      reset_n = 1'b0;
      zero_expect();
      #1;
      chk("async_rst_cyc", 64'(s_cyc_o), 64'h0);
      chk("async_rst_stb", 64'(s_stb_o), 64'h0);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_no_ack", 64'(ack_cnt - a0), 64'd0);

      // The decoder must be idle and usable after release.
      do_cycle(36'h0_0000_0400, 32'h0, 1'b0, 1, 32'h13572468, 0, -1, 1'b0, d);
      chk("post_rst_dat", 64'(m_dat_o), 64'h13572468);
      chk("post_rst_latency", 64'(d), 64'd4);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
